// File: rtl/nibble_seq_ctrl.sv
// Control sequencer for the 32-bit nibble selector: issues selA/selB/sel one item per cycle and
// presents valid/ready, index, source and last tags aligned with the selector's registered output.
module nibble_seq_ctrl #(
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [IDX_W-1:0] len,
    output logic             busy,
    output logic [IDX_W-1:0] selA,
    output logic [IDX_W-1:0] selB,
    output logic             sel,
    output logic             nib_valid,
    input  logic             nib_ready,
    output logic [IDX_W-1:0] nib_idx,
    output logic             nib_src,
    output logic             nib_last,
    output logic             done,
    output logic             err_mode
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [1:0] ModeB   = 2'b01;
    localparam logic [1:0] ModeIlv = 2'b10;
    localparam logic [1:0] ModeBad = 2'b11;

    state_e           fsm_q, fsm_d;
    logic [1:0]       job_mode_q, job_mode_d;
    logic [IDX_W-1:0] job_len_q, job_len_d;
    logic [IDX_W-1:0] nxt_idx_q, nxt_idx_d;
    logic             nxt_src_q, nxt_src_d;
    logic [IDX_W-1:0] disp_idx_q, disp_idx_d;
    logic             disp_src_q, disp_src_d;
    logic             issued_all_q, issued_all_d;
    logic             nib_valid_q, nib_valid_d;
    logic             done_q, done_d;
    logic             err_mode_q, err_mode_d;

    logic [IDX_W-1:0] item_idx;
    logic             item_src;
    logic             issue;
    logic             stall;
    logic             hs;
    logic [1:0]       cur_mode;
    logic [IDX_W-1:0] cur_len;

    function automatic logic is_final(input logic [IDX_W-1:0] idx, input logic src,
                                      input logic [1:0] m, input logic [IDX_W-1:0] l);
        return (idx == l) && (src == ((m == ModeIlv) ? 1'b1 : m[0]));
    endfunction

    assign stall     = nib_valid_q & ~nib_ready;
    assign hs        = nib_valid_q & nib_ready;
    // Job parameters come from the inputs on the accepting edge, from the job registers after.
    assign cur_mode  = (fsm_q == StIdle) ? mode : job_mode_q;
    assign cur_len   = (fsm_q == StIdle) ? len : job_len_q;
    assign nib_last  = nib_valid_q & issued_all_q & is_final(disp_idx_q, disp_src_q, job_mode_q,
                                                             job_len_q);

    always_comb begin
        fsm_d        = fsm_q;
        job_mode_d   = job_mode_q;
        job_len_d    = job_len_q;
        nxt_idx_d    = nxt_idx_q;
        nxt_src_d    = nxt_src_q;
        disp_idx_d   = disp_idx_q;
        disp_src_d   = disp_src_q;
        issued_all_d = issued_all_q;
        nib_valid_d  = nib_valid_q;
        done_d       = 1'b0;
        err_mode_d   = 1'b0;
        item_idx     = '0;
        item_src     = 1'b0;
        issue        = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                if (start) begin
                    if (mode == ModeBad) begin
                        err_mode_d = 1'b1;
                    end else begin
                        issue        = 1'b1;
                        item_src     = (mode == ModeB);
                        fsm_d        = StRun;
                        job_mode_d   = mode;
                        job_len_d    = len;
                        issued_all_d = 1'b0;
                    end
                end
            end
            StRun: begin
                if (stall) begin
                    // Re-present the displayed item so the selector recaptures the same nibble.
                    item_idx = disp_idx_q;
                    item_src = disp_src_q;
                end else if (!issued_all_q) begin
                    issue    = 1'b1;
                    item_idx = nxt_idx_q;
                    item_src = nxt_src_q;
                end
                if (hs && nib_last) begin
                    fsm_d        = StIdle;
                    nib_valid_d  = 1'b0;
                    done_d       = 1'b1;
                    issued_all_d = 1'b0;
                end else if (hs) begin
                    nib_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (issue) begin
            nib_valid_d = 1'b1;
            disp_idx_d  = item_idx;
            disp_src_d  = item_src;
            if (cur_mode == ModeIlv) begin
                nxt_src_d = ~item_src;
                nxt_idx_d = item_src ? item_idx + IDX_W'(1) : item_idx;
            end else begin
                nxt_src_d = item_src;
                nxt_idx_d = item_idx + IDX_W'(1);
            end
            if (is_final(item_idx, item_src, cur_mode, cur_len)) begin
                issued_all_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fsm_q        <= StIdle;
            job_mode_q   <= '0;
            job_len_q    <= '0;
            nxt_idx_q    <= '0;
            nxt_src_q    <= 1'b0;
            disp_idx_q   <= '0;
            disp_src_q   <= 1'b0;
            issued_all_q <= 1'b0;
            nib_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_mode_q   <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            job_mode_q   <= job_mode_d;
            job_len_q    <= job_len_d;
            nxt_idx_q    <= nxt_idx_d;
            nxt_src_q    <= nxt_src_d;
            disp_idx_q   <= disp_idx_d;
            disp_src_q   <= disp_src_d;
            issued_all_q <= issued_all_d;
            nib_valid_q  <= nib_valid_d;
            done_q       <= done_d;
            err_mode_q   <= err_mode_d;
        end
    end

    assign busy      = (fsm_q == StRun);
    assign selA      = item_idx;
    assign selB      = item_idx;
    assign sel       = item_src;
    assign nib_valid = nib_valid_q;
    assign nib_idx   = disp_idx_q;
    assign nib_src   = disp_src_q;
    assign done      = done_q;
    assign err_mode  = err_mode_q;

endmodule

// File: tb/tb_nibble_seq_ctrl.sv
// Directed bench for nibble_seq_ctrl with a behavioural copy of the nibble selector alongside it.
module tb_nibble_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  len = 3'd0;
    logic        busy;
    logic [2:0]  selA;
    logic [2:0]  selB;
    logic        sel;
    logic        nib_valid;
    logic        nib_ready = 1'b0;
    logic [2:0]  nib_idx;
    logic        nib_src;
    logic        nib_last;
    logic        done;
    logic        err_mode;
    logic [31:0] dataA = 32'h76543210;
    logic [31:0] dataB = 32'hFEDCBA98;
    logic [3:0]  nibble_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_seq_ctrl #(.IDX_W(3)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .mode      (mode),
        .len       (len),
        .busy      (busy),
        .selA      (selA),
        .selB      (selB),
        .sel       (sel),
        .nib_valid (nib_valid),
        .nib_ready (nib_ready),
        .nib_idx   (nib_idx),
        .nib_src   (nib_src),
        .nib_last  (nib_last),
        .done      (done),
        .err_mode  (err_mode)
    );

    // Selector model: registered nibble picked by sel/selA/selB, cleared on a clock with reset low.
    always @(posedge clk) begin
        if (!reset_L) nibble_out <= 4'h0;
        else nibble_out <= sel ? dataB[selB*4 +: 4] : dataA[selA*4 +: 4];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] ilv_nib [4] = '{4'h0, 4'h8, 4'h1, 4'h9};
    logic [2:0] ilv_idx [4] = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic       ilv_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_valid", nib_valid, 0);
        chk("rst_sel", {selA, selB, sel}, 0);
        chk("rst_pulses", {done, err_mode, nib_last}, 0);
        #9 reset_L = 1'b1;
        cyc();

        // A-only, len 7, consumer always ready
        start = 1'b1; mode = 2'b00; len = 3'd7; nib_ready = 1'b1;
        #1 chk("t1_first_sel", {selA, sel}, 0);
        cyc();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t1_valid", nib_valid, 1);
            chk("t1_busy", busy, 1);
            chk("t1_idx", nib_idx, k);
            chk("t1_nibble", nibble_out, k);
            chk("t1_last", nib_last, (k == 7));
            chk("t1_done_low", done, 0);
            cyc();
        end
        #1;
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_valid_end", nib_valid, 0);
        cyc();
        #1 chk("t1_done_pulse", done, 0);

        // Interleave, len 1
        start = 1'b1; mode = 2'b10; len = 3'd1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_valid", nib_valid, 1);
            chk("t2_nibble", nibble_out, ilv_nib[k]);
            chk("t2_idx", nib_idx, ilv_idx[k]);
            chk("t2_src", nib_src, ilv_src[k]);
            chk("t2_last", nib_last, (k == 3));
            cyc();
        end
        #1 chk("t2_done", {done, busy, nib_valid}, 3'b100);
        cyc();

        // B-only, len 3, backpressure while B1 is shown
        dataB = 32'h0000DCBA;
        start = 1'b1; mode = 2'b01; len = 3'd3;
        cyc();
        start = 1'b0;
        #1 chk("t3_b0", {nib_idx, nib_src, nibble_out}, {3'd0, 1'b1, 4'hA});
        cyc();
        nib_ready = 1'b0;
        #1 chk("t3_b1", {nib_idx, nib_src, nibble_out}, {3'd1, 1'b1, 4'hB});
        chk("t3_stall_sel", {selB, sel}, {3'd1, 1'b1});
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            chk("t3_hold_valid", nib_valid, 1);
            chk("t3_hold", {nib_idx, nib_src, nibble_out}, {3'd1, 1'b1, 4'hB});
            chk("t3_hold_last", nib_last, 0);
        end
        nib_ready = 1'b1;
        cyc();
        #1 chk("t3_b2", {nib_valid, nib_idx, nibble_out, nib_last}, {1'b1, 3'd2, 4'hC, 1'b0});
        cyc();
        #1 chk("t3_b3", {nib_valid, nib_idx, nibble_out, nib_last}, {1'b1, 3'd3, 4'hD, 1'b1});
        cyc();
        #1 chk("t3_done", {done, busy, nib_valid}, 3'b100);
        cyc();

        // Illegal mode, then start held during a run
        start = 1'b1; mode = 2'b11; len = 3'd2;
        #1 chk("t4_bad_sel", {selA, selB, sel}, 0);
        cyc();
        start = 1'b0;
        #1 chk("t4_err", {err_mode, busy, nib_valid}, 3'b100);
        cyc();
        #1 chk("t4_err_pulse", err_mode, 0);
        start = 1'b1; mode = 2'b00; len = 3'd3;
        cyc();
        mode = 2'b10; len = 3'd7;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) start = 1'b0;
            #1;
            chk("t4_idx", {nib_valid, nib_idx, nib_src}, {1'b1, 3'(k), 1'b0});
            chk("t4_nibble", nibble_out, k);
            chk("t4_last", nib_last, (k == 3));
            cyc();
        end
        #1 chk("t4_done", {done, busy, nib_valid}, 3'b100);
        cyc();

        // Asynchronous reset mid-job, then a single-nibble job
        start = 1'b1; mode = 2'b00; len = 3'd7;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        #1 chk("t5_pre", {nib_idx, nibble_out}, {3'd3, 4'h3});
        #1 reset_L = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_valid", nib_valid, 0);
        chk("t5_sel", {selA, selB, sel}, 0);
        chk("t5_done", done, 0);
        cyc();
        #1 chk("t5_sel_clear", {nibble_out, done}, 0);
        reset_L = 1'b1;
        cyc();
        #1 chk("t5_idle", {busy, done, nib_valid}, 0);
        dataA = 32'h76543215;
        start = 1'b1; mode = 2'b00; len = 3'd0;
        cyc();
        start = 1'b0;
        #1 chk("t5_single", {nib_valid, nib_idx, nibble_out, nib_last}, {1'b1, 3'd0, 4'h5, 1'b1});
        cyc();
        #1 chk("t5_single_done", {done, busy, nib_valid}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_seq_ctrl.md
Name: nibble_seq_ctrl

Overview:
- Sequencer that drives the nibble selector's selA/selB/sel inputs to stream nibbles out of dataA/dataB, one per cycle.
- Produces a valid/ready handshake, an index and source tag, and a last flag, all aligned with the selector's registered nibbleOut.
- Sits beside the selector. The nibble data itself never passes through this block; only control and tags do.
- The upstream owner must hold dataA/dataB stable while busy=1.

Parameters:
- IDX_W, 3, nibble index width. The selector addresses 2^IDX_W nibbles per word; it is fixed at 3 for the 32-bit selector.

Ports:
- clk  in  1  clock, shared with the selector.
- reset_L  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- mode  in  2  job type: 00 = A only, 01 = B only, 10 = interleave A0,B0,A1,B1,..., 11 = illegal.
- len  in  IDX_W  nibbles per word minus 1 (0..7); sampled with start.
- busy  out  1  job in progress.
- selA  out  IDX_W  to the selector's selA.
- selB  out  IDX_W  to the selector's selB.
- sel  out  1  to the selector's sel; 1 = B, 0 = A.
- nib_valid  out  1  the selector's nibbleOut holds a job nibble this cycle.
- nib_ready  in  1  consumer accepts the nibble.
- nib_idx  out  IDX_W  nibble index of the presented nibble.
- nib_src  out  1  0 = from A, 1 = from B.
- nib_last  out  1  presented nibble is the final one of the job.
- done  out  1  one-cycle pulse on the cycle after the last handshake.
- err_mode  out  1  one-cycle pulse when start arrives with mode=11.

Behaviour:
- Registered state: fsm (IDLE, RUN), job_mode, job_len, next item (idx, src), displayed item (disp_idx, disp_src), issued_all flag, nib_valid, done, err_mode.
- Async reset (reset_L low, any time, including mid-job):
  - fsm=IDLE; all registered outputs 0.
  - selA=selB=0, sel=0; job aborted with no done.
  - The selector's own nibbleOut clears on its next clock while reset is low.
- selA, selB and sel are combinational from the registers:
  - IDLE with start and a legal mode: first item (idx 0; src 1 if mode=01, else 0).
  - RUN with stall = nib_valid & ~nib_ready: the displayed item (disp_idx, disp_src). The selector recaptures the same nibble, so nibbleOut holds steady.
  - RUN without stall and ~issued_all: the next item.
  - Otherwise: idx 0, sel 0.
  - selA and selB both carry the item idx; sel carries src.
- Issue event: an edge where the combinational select carries a new item (IDLE start, or RUN & ~stall & ~issued_all). On an issue event:
  - nib_valid<=1; disp<=issued item.
  - next advances in job order:
    - A-only / B-only: idx+1.
    - Interleave: src toggles; idx increments after B.
  - When the issued item is the final one, issued_all<=1.
- Latency: start sampled at edge E → nibble 0 is in nibbleOut with nib_valid=1 after E. One nibble per cycle is sustained while nib_ready=1.
- Item count is len+1 for A-only/B-only and 2*(len+1) for interleave. The final item is idx=len, src=mode[0] for single-word modes and src=1 for interleave.
- nib_idx=disp_idx and nib_src=disp_src.
- nib_last = nib_valid & issued_all & (disp equals the final item).
- Handshake:
  - A nibble transfers on nib_valid & nib_ready.
  - No issue event with nib_ready=1 and no stall → nib_valid<=0.
  - nib_valid never drops without a handshake.
- Completion: a handshake with nib_last=1 → fsm<=IDLE, busy<=0, done<=1 for one cycle, nib_valid<=0.
- busy: 1 from the start-accept edge through the final handshake edge.
- start behaviour:
  - start in RUN is ignored.
  - start in the same cycle as the final handshake is ignored; it needs IDLE.
  - start with mode=11 in IDLE: err_mode pulse, remain IDLE, no select change, nib_valid stays 0.
- Wrap: with len=7, idx never exceeds 7 and never wraps within a job. The next job restarts at idx 0.

Test Plan:
- dataA=32'h76543210, mode=00, len=7, nib_ready=1 → nibbleOut 0..7 on 8 consecutive nib_valid cycles; nib_idx 0..7; nib_last only on 7; done one cycle later; busy high for 8 cycles.
- dataA=32'h76543210, dataB=32'hFEDCBA98, mode=10, len=1 → nibbles 0,8,1,9 with nib_src 0,1,0,1; 4 transfers; done pulse.
- mode=01, len=3, dataB=32'h0000DCBA; deassert nib_ready for 3 cycles while nibble B idx1 (B) is shown → nibbleOut, nib_idx and nib_valid stay frozen; sequence resumes with C, D in order, with no loss or duplicate.
- start with mode=11 in IDLE → err_mode 1-cycle pulse, busy=0, nib_valid=0; start pulsed during RUN → ignored, the job completes unchanged.
- Drop reset_L mid-job after 3 transfers (asynchronously, between edges) → busy, nib_valid, selA/selB/sel go 0 immediately with no done; after release, a new mode=00 len=0 job yields a single nibble dataA[3:0] with nib_last=1.
